psg_bus_sequencer: RTL and testbench
====================================

// Module: psg_bus_sequencer
// PURPOSE
//  Sequences register accesses from two requesters onto the YM2149 PSG's BDIR/BC/DI/DO bus.
//  Requesters: port 0 = Z80 I/O decode; port 1 = system/debug agent.
//  Converts each request into latch-address + write/read bus phases, exactly one CLK each.
//  Shares the PSG between the two requesters with round-robin arbitration.
//  Sits between the I/O decoder and the PSG, in the same CLK domain; PSG CE is independent.
// PARAMETERS
//  GAP         1  idle CLK cycles (BDIR=0,BC=0) after every transaction; 0..15, 0 = back-to-back
//  ADDR_CACHE  1  1 = skip address phase when the PSG's latched address already equals the request
// PORTS
//  CLK           in   1  system clock
//  RESET         in   1  synchronous, active-high reset
//  req_valid     in   2  per-requester request pending
//  req_write     in   2  per-requester: 1 = write, 0 = read
//  req_addr      in   2x8  per-requester PSG register address
//  req_data      in   2x8  per-requester write data
//  req_ready     out  2  one-hot accept strobe; request consumed in the cycle valid&ready
//  rsp_valid     out  2  one-cycle read-data strobe to the owning requester
//  rsp_data      out  8  read data; held until next read completes
//  psg_bdir      out  1  to PSG BDIR
//  psg_bc        out  1  to PSG BC
//  psg_di        out  8  to PSG DI
//  psg_do        in   8  from PSG DO (combinational in PSG)
//  busy          out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: every output = 0; state IDLE; address cache invalid; RR pointer = 1 so requester 0 wins first.
//  States: IDLE -> ADDR -> (WR | RD) -> GAP -> IDLE.
//   - ADDR is skipped when the cache is hit.
//   - GAP is skipped when GAP == 0.
//  IDLE
//   - If any req_valid: grant one, assert its req_ready for that cycle.
//   - Latch addr/data/write/owner.
//   - req_ready is asserted only in IDLE, at most one bit.
//  Arbitration
//   - Single valid: grant it.
//   - Both valid: grant the index != last grant, then update last grant.
//  ADDR:  bdir=1 bc=1 di=addr; set cache = {1, addr}.
//  WR:    bdir=1 bc=0 di=data.
//   - Exactly one cycle, since the PSG writes on every CLK that BDIR is high.
//  RD:    bdir=0 bc=1 di=0; sample psg_do at end of cycle into rsp_data.
//   - Pulse rsp_valid[owner] in the following cycle, the first cycle of GAP or IDLE.
//  GAP:   bdir=0 bc=0 di=0 for GAP cycles (4-bit down-counter), then IDLE.
//  All other states drive bdir=0 bc=0 di=0. bdir and bc are registered: no combinational req->psg path.
//  Cache
//   - Compares the full 8-bit address; addresses >= 16 are passed through unchanged.
//   - The PSG ignores writes to them and reads return 0xFF; the sequencer does not filter them.
//  Latency, cycle 0 = accept:
//   - Write, miss: ADDR @1, WR @2, free @3+GAP.
//   - Write, hit: WR @1.
//   - Read, miss: ADDR @1, RD @2, rsp_valid @3.
//   - Read, hit: RD @1, rsp_valid @2.
//  Minimum issue interval = phases + GAP + 1 (IDLE cycle).
//  Simultaneous events
//   - A new request arriving during a transaction waits; valid must hold until ready.
//   - A requester may re-request in the same cycle its rsp_valid fires.
//  RESET mid-transaction
//   - Abort immediately to IDLE; cache invalid; pending rsp_valid suppressed.
//   - Outputs go to 0 next cycle; a half-done write never issues its WR phase.
//  Write to reg 13 is issued every time, even on a cache hit, so the PSG envelope restarts.
// STRUCTURE
//  Package psg_seq_pkg:
//   - state_t enum {IDLE, ADDR, WR, RD, GAP}.
//   - Bus phase constants PH_INACT=2'b00, PH_READ=2'b01, PH_WRITE=2'b10, PH_ADDR=2'b11 ({bdir,bc}).
//   - PSG_REG_ENV_SHAPE = 8'd13.
//  Sub-module psg_rr_arbiter: 2-way round-robin.
//   - Inputs: valid[1:0], advance.
//   - Outputs: grant one-hot, last-grant pointer.
//  Everything else stays in this module.
// TESTING
//  1. Reset, then req0 write addr=0x07 data=0x38.
//     -> {bdir,bc}=11 di=07 @1; 10 di=38 @2; 00 @3; PSG reg7=0x38.
//  2. Repeat req0 write addr=0x07 data=0x3F (ADDR_CACHE=1).
//     -> no ADDR phase; WR di=3F @1.
//     Then write addr=0x0D twice -> two WR cycles, envelope restarts both times.
//  3. Both valid at once from reset, req0 write 0x08, req1 read 0x08.
//     -> req0 granted first, req1 next.
//     -> rsp_valid=2'b10 with rsp_data = value written & 0x1F.
//  4. Both requesters hold valid continuously for 8 transactions.
//     -> grants alternate 0,1,0,1...
//     -> each grant separated by phases+GAP+1 cycles; never two req_ready bits set.
//  5. Read addr=0x20.
//     -> ADDR di=20, RD, rsp_data=0xFF; a following write to 0x20 leaves PSG regs unchanged.
//  6. RESET asserted in the ADDR cycle of a write.
//     -> next cycle bdir=bc=0, busy=0, no WR issued, no rsp_valid.
//     -> the next access to the same address performs a full ADDR phase.

Source files
------------

// File: rtl/psg_seq_pkg.sv
// Shared types and constants for the YM2149 PSG bus sequencer.
package psg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Bus phase encodings as {bdir, bc}
  localparam logic [1:0] PH_INACT = 2'b00;
  localparam logic [1:0] PH_READ  = 2'b01;
  localparam logic [1:0] PH_WRITE = 2'b10;
  localparam logic [1:0] PH_ADDR  = 2'b11;

  localparam logic [7:0] PSG_REG_ENV_SHAPE = 8'd13;

endpackage

// File: rtl/psg_rr_arbiter.sv
// Two-way round-robin arbiter; the requester that did not win last time wins a tie.
module psg_rr_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last
);

  // One-hot grant selection from the pending requests and the last winner
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner of each accepted request; reset favours requester 0
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/psg_bus_sequencer.sv
// Sequences requests from two masters onto the YM2149 BDIR/BC/DI/DO bus.
module psg_bus_sequencer #(
  parameter int unsigned GAP        = 1,
  parameter bit          ADDR_CACHE = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_write,
  input  logic [1:0][7:0] req_addr,
  input  logic [1:0][7:0] req_data,
  output logic [1:0]      req_ready,
  output logic [1:0]      rsp_valid,
  output logic [7:0]      rsp_data,
  output logic            psg_bdir,
  output logic            psg_bc,
  output logic [7:0]      psg_di,
  input  logic [7:0]      psg_do,
  output logic            busy
);
  import psg_seq_pkg::*;

  localparam int unsigned GAP_W = 4;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       grant;
  logic             last;
  logic             advance;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;
  logic             write_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             cache_valid;
  logic [7:0]       cache_addr;
  logic [7:0]       cur_addr;
  logic [7:0]       cur_data;
  logic             cur_write;
  logic             cache_hit;
  logic [1:0]       phase_d;
  logic [7:0]       di_d;

  psg_rr_arbiter u_arb (
    .CLK     (CLK),
    .RESET   (RESET),
    .valid   (req_valid),
    .advance (advance),
    .grant   (grant),
    .last    (last)
  );

  // Accept only from IDLE; the arbiter pointer doubles as the transaction owner
  assign advance   = (state_q == IDLE) && (req_valid != 2'b00) && !RESET;
  assign req_ready = advance ? grant : 2'b00;

  // Request fields come straight from the winner while accepting, else from the latch
  assign cur_addr  = (state_q == IDLE) ? req_addr[grant[1]]  : addr_q;
  assign cur_data  = (state_q == IDLE) ? req_data[grant[1]]  : data_q;
  assign cur_write = (state_q == IDLE) ? req_write[grant[1]] : write_q;
  assign cache_hit = ADDR_CACHE && cache_valid && (cache_addr == cur_addr);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (advance) begin
          if (cache_hit) state_d = cur_write ? WR : RD;
          else           state_d = ADDR;
        end
      end
      ADDR:             state_d = write_q ? WR : RD;
      WR, RD:           state_d = (GAP == 0) ? IDLE : psg_seq_pkg::GAP;
      psg_seq_pkg::GAP: if (gap_cnt == '0) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Bus phase for the upcoming cycle, registered below
  always_comb begin
    phase_d = PH_INACT;
    di_d    = 8'h00;
    case (state_d)
      ADDR: begin
        phase_d = PH_ADDR;
        di_d    = cur_addr;
      end
      WR: begin
        phase_d = PH_WRITE;
        di_d    = cur_data;
      end
      RD:      phase_d = PH_READ;
      default: phase_d = PH_INACT;
    endcase
  end

  // Request latch, gap counter, address cache, read response and registered bus outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      write_q     <= 1'b0;
      gap_cnt     <= '0;
      cache_valid <= 1'b0;
      cache_addr  <= 8'h00;
      rsp_valid   <= 2'b00;
      rsp_data    <= 8'h00;
      psg_bdir    <= 1'b0;
      psg_bc      <= 1'b0;
      psg_di      <= 8'h00;
      busy        <= 1'b0;
    end else begin
      if (advance) begin
        addr_q  <= cur_addr;
        data_q  <= cur_data;
        write_q <= cur_write;
      end
      if ((state_d == psg_seq_pkg::GAP) && (state_q != psg_seq_pkg::GAP)) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state_q == psg_seq_pkg::GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
      if (state_q == ADDR) begin
        cache_valid <= 1'b1;
        cache_addr  <= addr_q;
      end
      rsp_valid <= (state_q == RD) ? (last ? 2'b10 : 2'b01) : 2'b00;
      if (state_q == RD) begin
        rsp_data <= psg_do;
      end
      {psg_bdir, psg_bc} <= phase_d;
      psg_di             <= di_d;
      busy               <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Self-checking bench for psg_bus_sequencer with a behavioural YM2149 register model.
module tb_psg_bus_sequencer;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [1:0][7:0] req_addr;
  logic [1:0][7:0] req_data;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [7:0]      rsp_data;
  logic            psg_bdir;
  logic            psg_bc;
  logic [7:0]      psg_di;
  logic [7:0]      psg_do;
  logic            busy;

  int checks = 0;
  int failures = 0;

  psg_bus_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .psg_bdir  (psg_bdir),
    .psg_bc    (psg_bc),
    .psg_di    (psg_di),
    .psg_do    (psg_do),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Implemented bits of each YM2149 register
  function automatic logic [7:0] reg_mask(input logic [3:0] r);
    case (r)
      4'd1, 4'd3, 4'd5, 4'd13:  return 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:  return 8'h1F;
      default:                  return 8'hFF;
    endcase
  endfunction

  // PSG model: latches address on 11, writes on 10, DO combinational from latched address
  logic       psg_por;
  logic [7:0] psg_lat;
  logic [7:0] psg_reg [16];
  int         env_restarts;

  always @(posedge CLK) begin
    if (psg_por) begin
      psg_lat      <= 8'hFF;
      env_restarts <= 0;
      for (int r = 0; r < 16; r++) psg_reg[r] <= 8'h00;
    end else if (psg_bdir && psg_bc) begin
      psg_lat <= psg_di;
    end else if (psg_bdir && !psg_bc && (psg_lat < 8'd16)) begin
      psg_reg[psg_lat[3:0]] <= psg_di & reg_mask(psg_lat[3:0]);
      if (psg_lat == 8'd13) env_restarts <= env_restarts + 1;
    end
  end

  assign psg_do = (psg_lat < 8'd16) ? psg_reg[psg_lat[3:0]] : 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    req_valid = 2'b00;
    tick();
    RESET = 1'b0;
  endtask

  // Directed cycle vectors (requester 0 only)
  typedef struct {
    logic [1:0] rv;
    logic [1:0] rw;
    logic [7:0] a0;
    logic [7:0] d0;
    logic [1:0] rdy;
    logic [1:0] ph;
    logic [7:0] di;
    logic       bsy;
    logic [1:0] rspv;
    logic [7:0] rspd;
  } vec_t;

  function automatic vec_t V(input logic [1:0] rv, input logic [1:0] rw, input logic [7:0] a0,
                             input logic [7:0] d0, input logic [1:0] rdy, input logic [1:0] ph,
                             input logic [7:0] di, input logic bsy, input logic [1:0] rspv,
                             input logic [7:0] rspd);
    vec_t v;
    v.rv = rv; v.rw = rw; v.a0 = a0; v.d0 = d0; v.rdy = rdy; v.ph = ph;
    v.di = di; v.bsy = bsy; v.rspv = rspv; v.rspd = rspd;
    return v;
  endfunction

  // Transaction-level reference: expected per-cycle bus activity after each accept
  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] di;
    logic [1:0] rv;
    logic [7:0] rd;
  } exp_t;

  exp_t       exp_q[$];
  logic       ref_last;
  logic       ref_cv;
  logic [7:0] ref_ca;
  logic [7:0] ref_regs [16];
  logic [1:0] acc;
  int         grants[$];

  function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic lst);
    if (v == 2'b11) return lst ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(4))
      0:       return 8'h07;
      1:       return 8'h08;
      2:       return 8'h0D;
      3:       return 8'h20;
      default: return 8'($urandom_range(31));
    endcase
  endfunction

  task automatic monitor_cycle();
    exp_t       e;
    logic [1:0] er;
    logic       bsy;
    int         i;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rdv;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      er  = 2'b00;
      bsy = 1'b1;
    end else begin
      e   = '0;
      er  = rr_pick(req_valid, ref_last);
      bsy = 1'b0;
    end
    check("rand_ready", 32'(req_ready), 32'(er));
    check("rand_bus", 32'({busy, psg_bdir, psg_bc, psg_di}), 32'({bsy, e.ph, e.di}));
    check("rand_rsp_valid", 32'(rsp_valid), 32'(e.rv));
    if (e.rv != 2'b00) check("rand_rsp_data", 32'(rsp_data), 32'(e.rd));
    if (er != 2'b00) begin
      i        = er[1] ? 1 : 0;
      ref_last = er[1];
      acc[i]   = 1'b1;
      grants.push_back(i);
      a = req_addr[i];
      d = req_data[i];
      if (!(ref_cv && ref_ca == a)) begin
        exp_q.push_back('{2'b11, a, 2'b00, 8'h00});
        ref_cv = 1'b1;
        ref_ca = a;
      end
      if (req_write[i]) begin
        exp_q.push_back('{2'b10, d, 2'b00, 8'h00});
        exp_q.push_back('{2'b00, 8'h00, 2'b00, 8'h00});
        if (a < 8'd16) ref_regs[a[3:0]] = d & reg_mask(a[3:0]);
      end else begin
        rdv = (a < 8'd16) ? ref_regs[a[3:0]] : 8'hFF;
        exp_q.push_back('{2'b01, 8'h00, 2'b00, 8'h00});
        exp_q.push_back('{2'b00, 8'h00, er, rdv});
      end
    end
  endtask

  task automatic drive_cycle(input int pct);
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        req_valid[i] = 1'b0;
        acc[i]       = 1'b0;
      end
      if (!req_valid[i] && (int'($urandom_range(99)) < pct)) begin
        req_valid[i] = 1'b1;
        req_write[i] = 1'($urandom_range(1));
        req_addr[i]  = pick_addr();
        req_data[i]  = 8'($urandom);
      end
    end
  endtask

  task automatic one_cycle(input int pct);
    drive_cycle(pct);
    @(negedge CLK);
    monitor_cycle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int   found;
    logic [7:0] rd_hold;

    // Reset state with both requests pending: nothing may be granted
    RESET     = 1'b1;
    psg_por   = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = '0;
    req_data  = '0;
    tick();
    psg_por = 1'b0;
    @(negedge CLK);
    check("reset_outputs",
          32'({req_ready, rsp_valid, rsp_data, psg_bdir, psg_bc, psg_di, busy}), 32'(0));
    tick();
    req_valid = 2'b00;
    RESET     = 1'b0;

    // Tests 1, 2 and 5 as cycle vectors
    rd_hold = 8'h00;
    vecs.push_back(V(2'b01, 2'b01, 8'h07, 8'h38, 2'b01, 2'b00, 8'h00, 1'b0, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 8'h07, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h38, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 2'b00, rd_hold));
    vecs.push_back(V(2'b01, 2'b01, 8'h07, 8'h3F, 2'b01, 2'b00, 8'h00, 1'b0, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h3F, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b01, 2'b01, 8'h0D, 8'h0E, 2'b01, 2'b00, 8'h00, 1'b0, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 8'h0D, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h0E, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b01, 2'b01, 8'h0D, 8'h09, 2'b01, 2'b00, 8'h00, 1'b0, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h09, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b01, 2'b00, 8'h20, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 8'h20, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h00, 1'b1, 2'b00, rd_hold));
    rd_hold = 8'hFF;
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b01, rd_hold));
    vecs.push_back(V(2'b01, 2'b01, 8'h20, 8'h55, 2'b01, 2'b00, 8'h00, 1'b0, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h55, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, rd_hold));
    vecs.push_back(V(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 2'b00, rd_hold));

    for (int i = 0; i < vecs.size(); i++) begin
      req_valid   = vecs[i].rv;
      req_write   = vecs[i].rw;
      req_addr[0] = vecs[i].a0;
      req_data[0] = vecs[i].d0;
      req_addr[1] = 8'h00;
      req_data[1] = 8'h00;
      @(negedge CLK);
      check($sformatf("vec%0d", i),
            32'({req_ready, psg_bdir, psg_bc, psg_di, busy, rsp_valid, rsp_data}),
            32'({vecs[i].rdy, vecs[i].ph, vecs[i].di, vecs[i].bsy, vecs[i].rspv, vecs[i].rspd}));
      if (i == 4) check("psg_reg7_first", 32'(psg_reg[7]), 32'(8'h38));
      tick();
    end
    req_valid = 2'b00;
    check("psg_reg7", 32'(psg_reg[7]), 32'(8'h3F));
    check("psg_reg13", 32'(psg_reg[13]), 32'(8'h09));
    check("env_restarts", 32'(env_restarts), 32'(2));

    // Test 3: simultaneous requests from reset, write then read of reg 8
    do_reset();
    req_valid   = 2'b11;
    req_write   = 2'b01;
    req_addr[0] = 8'h08;
    req_data[0] = 8'h3A;
    req_addr[1] = 8'h08;
    req_data[1] = 8'h00;
    @(negedge CLK);
    check("t3_first_grant", 32'(req_ready), 32'(2'b01));
    tick();
    req_valid = 2'b10;
    found = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (req_ready != 2'b00) begin
        found = k;
        break;
      end
      tick();
    end
    check("t3_second_grant_cycle", 32'(found), 32'(4));
    check("t3_second_grant", 32'(req_ready), 32'(2'b10));
    tick();
    req_valid = 2'b00;
    @(negedge CLK);
    check("t3_rd_phase", 32'({psg_bdir, psg_bc, psg_di}), 32'({2'b01, 8'h00}));
    tick();
    @(negedge CLK);
    check("t3_rsp", 32'({rsp_valid, rsp_data}), 32'({2'b10, 8'h1A}));
    tick();

    // Test 6: reset during the ADDR phase of a write aborts it cleanly
    req_valid   = 2'b01;
    req_write   = 2'b01;
    req_addr[0] = 8'h05;
    req_data[0] = 8'h0A;
    @(negedge CLK);
    check("t6_accept", 32'(req_ready), 32'(2'b01));
    tick();
    RESET     = 1'b1;
    req_valid = 2'b00;
    @(negedge CLK);
    check("t6_addr_phase", 32'({psg_bdir, psg_bc, psg_di}), 32'({2'b11, 8'h05}));
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("t6_after_reset", 32'({req_ready, rsp_valid, psg_bdir, psg_bc, psg_di, busy}), 32'(0));
    tick();
    @(negedge CLK);
    check("t6_no_wr", 32'({psg_bdir, psg_bc, busy, rsp_valid}), 32'(0));
    check("t6_reg5_untouched", 32'(psg_reg[5]), 32'(8'h00));
    tick();
    req_valid   = 2'b01;
    req_data[0] = 8'h0B;
    @(negedge CLK);
    check("t6_reaccept", 32'(req_ready), 32'(2'b01));
    tick();
    req_valid = 2'b00;
    @(negedge CLK);
    check("t6_full_addr", 32'({psg_bdir, psg_bc, psg_di}), 32'({2'b11, 8'h05}));
    tick();
    tick();
    @(negedge CLK);
    check("t6_reg5_written", 32'(psg_reg[5]), 32'(8'h0B));
    tick();

    // Test 4: both requesters always valid -> strict alternation
    do_reset();
    exp_q.delete();
    grants.delete();
    ref_last = 1'b1;
    ref_cv   = 1'b0;
    ref_ca   = 8'h00;
    acc      = 2'b00;
    for (int r = 0; r < 16; r++) ref_regs[r] = psg_reg[r];
    for (int c = 0; c < 80 && grants.size() < 8; c++) one_cycle(100);
    check("t4_grant_count", 32'(grants.size() >= 8), 32'(1));
    if (grants.size() >= 8) begin
      check("t4_first", 32'(grants[0]), 32'(0));
      for (int k = 1; k < 8; k++) check($sformatf("t4_alt%0d", k), 32'(grants[k]), 32'(1 - grants[k-1]));
    end

    // Random traffic against the reference
    for (int c = 0; c < 900; c++) one_cycle(35);
    found = 0;
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && req_valid == 2'b00 && acc == 2'b00) begin
        found = 1;
        break;
      end
      one_cycle(0);
    end
    check("drain", 32'(found), 32'(1));
    for (int r = 0; r < 16; r++) check($sformatf("final_reg%0d", r), 32'(psg_reg[r]), 32'(ref_regs[r]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
